// File: rtl/instr_mem_responder.sv
// Instruction-fetch read responder: synchronous-read instruction store with fixed-latency
// word return, flush abort of in-flight reads, and an independent preload/write port.
module instr_mem_responder #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] instruction_rd1,
    input  logic                  rd_req,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] instruction_rd1_out,
    output logic                  rd_valid,
    output logic                  rd_error,
    input  logic                  flush,
    input  logic                  load_enable,
    input  logic [ADDR_WIDTH-1:0] load_address,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int                    DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] LIMIT     = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0]            WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_count, w_count_nxt;
    logic [ADDR_WIDTH-1:0] r_addr_q, w_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_fetch_addr;
    logic                  w_accept;
    logic                  w_fetch;
    logic                  w_fetch_oor;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign rd_ready    = ((r_state == S_IDLE) || (r_state == S_RESP)) && !flush;
    assign rd_valid    = (r_state == S_RESP) && !flush;
    assign w_accept    = rd_req && rd_ready;
    assign w_fetch_oor = (w_fetch_addr >= LIMIT);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_addr_nxt   = r_addr_q;
        w_fetch      = 1'b0;
        w_fetch_addr = r_addr_q;
        if (flush) begin
            // A redirect beats both a new request and an expiring wait.
            w_state_nxt = S_IDLE;
            w_count_nxt = 4'd0;
        end else begin
            unique case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        w_addr_nxt = instruction_rd1;
                        if (WAIT_STATES == 0) begin
                            w_state_nxt  = S_RESP;
                            w_fetch      = 1'b1;
                            w_fetch_addr = instruction_rd1;
                        end else begin
                            w_state_nxt = S_WAIT;
                            w_count_nxt = WAIT_INIT;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_count == 4'd0) begin
                        w_state_nxt = S_RESP;
                        w_fetch     = 1'b1;
                    end else begin
                        w_count_nxt = r_count - 4'd1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state             <= S_IDLE;
            r_count             <= 4'd0;
            r_addr_q            <= '0;
            instruction_rd1_out <= '0;
            rd_error            <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_addr_q <= w_addr_nxt;
            if (w_fetch) begin
                if (w_fetch_oor) begin
                    instruction_rd1_out <= '0;
                    rd_error            <= 1'b1;
                end else begin
                    instruction_rd1_out <= r_mem[w_fetch_addr[DEPTH_LOG2-1:0]];
                    rd_error            <= 1'b0;
                end
            end
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM; a same-edge read sees the old word.
    always_ff @(posedge clock) begin
        if (load_enable && (load_address < LIMIT)) begin
            r_mem[load_address[DEPTH_LOG2-1:0]] <= load_data;
        end
    end

endmodule
